// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed seven-segment scanner with blanking gap and leading-zero suppression
module seven_seg_scan #(
  parameter int N_DIGITS  = 4,
  parameter int ON_CYC    = 50000,
  parameter int BLANK_CYC = 500,
  parameter int HEX_EN    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_lzb,
  input  logic [4*N_DIGITS-1:0]   i_digits,
  input  logic [N_DIGITS-1:0]     i_dp,
  output logic [N_DIGITS-1:0]     o_dig,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ON    = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0]   digits_q, digits_d;
  logic [N_DIGITS-1:0]     dp_q, dp_d;
  logic                    lzb_q, lzb_d;
  logic [N_DIGITS-1:0]     dig_q, dig_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic                    frame_q, frame_d;

  logic                    next_digit;
  logic                    load;
  logic [3:0]              cur_code;
  logic                    upper_nonzero;
  logic                    lead_blank;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = (HEX_EN != 0) ? 7'b0001000 : 7'b1111111;
      4'hB: seg = (HEX_EN != 0) ? 7'b1100000 : 7'b1111111;
      4'hC: seg = (HEX_EN != 0) ? 7'b0110001 : 7'b1111111;
      4'hD: seg = (HEX_EN != 0) ? 7'b1000010 : 7'b1111111;
      4'hE: seg = (HEX_EN != 0) ? 7'b0110000 : 7'b1111111;
      default: seg = (HEX_EN != 0) ? 7'b0111000 : 7'b1111111;
    endcase
    return seg;
  endfunction

  // Scan sequencing; disable overrides everything and parks the scanner in IDLE.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    next_digit = 1'b0;
    load       = 1'b0;

    if (!i_en) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ON;
          idx_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
        S_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_d = '0;
            if (BLANK_CYC == 0) begin
              next_digit = 1'b1;
            end else begin
              state_d = S_BLANK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_d      = '0;
            state_d    = S_ON;
            next_digit = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase

      if (next_digit) begin
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          load  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    lzb_d    = lzb_q;
    frame_d  = 1'b0;
    if (load) begin
      digits_d = i_digits;
      dp_d     = i_dp;
      lzb_d    = i_lzb;
      frame_d  = 1'b1;
    end
  end

  // Outputs are computed from next-state values so they settle on the same edge as the FSM.
  always_comb begin
    cur_code      = digits_d[4*idx_d +: 4];
    upper_nonzero = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k >= int'(idx_d) && digits_d[4*k +: 4] != 4'h0) begin
        upper_nonzero = 1'b1;
      end
    end
    lead_blank = lzb_d && (idx_d != '0) && !upper_nonzero;

    dig_d = '0;
    seg_d = 7'b1111111;
    dpo_d = 1'b1;
    if (state_d == S_ON) begin
      dig_d = N_DIGITS'(1) << idx_d;
      seg_d = lead_blank ? 7'b1111111 : decode(cur_code);
      dpo_d = ~dp_d[idx_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      lzb_q    <= 1'b0;
      dig_q    <= '0;
      seg_q    <= 7'b1111111;
      dpo_q    <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      dp_q     <= dp_d;
      lzb_q    <= lzb_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      dpo_q    <= dpo_d;
      frame_q  <= frame_d;
    end
  end

  assign o_dig   = dig_q;
  assign o_seg   = seg_q;
  assign o_dp    = dpo_q;
  assign o_frame = frame_q;

endmodule
